// File: rtl/instr_seq_pkg.sv
// Shared opcode map, sequencer state encoding and decoded-line payload for instr_seq.
// WAIT state exists only when SINGLE_STEP_EN is defined.
package instr_seq_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned DEC_W = 16;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_HALT = 4'h1;
    localparam logic [OP_W-1:0] OP_IN1  = 4'h2;
    localparam logic [OP_W-1:0] OP_OUT1 = 4'h3;
    localparam logic [OP_W-1:0] OP_JMP  = 4'h4;
    localparam logic [OP_W-1:0] OP_JZ   = 4'h5;
    localparam logic [OP_W-1:0] OP_JC   = 4'h6;
    localparam logic [OP_W-1:0] OP_RSL  = 4'h7;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h8;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h9;
    localparam logic [OP_W-1:0] OP_AND1 = 4'hA;
    localparam logic [OP_W-1:0] OP_NOT1 = 4'hB;
    localparam logic [OP_W-1:0] OP_MOVA = 4'hC;
    localparam logic [OP_W-1:0] OP_MOVB = 4'hD;
    localparam logic [OP_W-1:0] OP_MOVC = 4'hE;
    localparam logic [OP_W-1:0] OP_RSR  = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_HALTED = 3'd3
`ifdef SINGLE_STEP_EN
        ,
        S_WAIT   = 3'd4
`endif
    } state_t;

    // Field order puts opcode N at bit N of the packed vector.
    typedef struct packed {
        logic rsr;
        logic movc;
        logic movb;
        logic mova;
        logic not1;
        logic and1;
        logic sub;
        logic add;
        logic rsl;
        logic jc;
        logic jz;
        logic jmp;
        logic out1;
        logic in1;
        logic halt;
        logic nop;
    } dec_t;

endpackage

// File: rtl/instr_dec.sv
// Gated opcode-to-one-hot decoder: one line in EXEC, halt held in HALTED, else all zero.
module instr_dec
    import instr_seq_pkg::*;
(
    input  logic [OP_W-1:0] i_op,
    input  logic            i_exec,
    input  logic            i_halted,
    output dec_t            o_dec
);

    always_comb begin
        o_dec = '0;
        if (i_exec) begin
            o_dec = dec_t'(DEC_W'(1) << i_op);
        end else if (i_halted) begin
            o_dec.halt = 1'b1;
        end
    end

endmodule

// File: rtl/instr_seq.sv
// Instruction sequencer: IDLE/FETCH/EXEC/HALTED control with retired-instruction counter.
// Optional single-step (WAIT state, step synchroniser) under SINGLE_STEP_EN.
module instr_seq
    import instr_seq_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
`ifdef SINGLE_STEP_EN
    input  logic             i_step_mode,
    input  logic             i_step,
`endif
    input  logic [7:0]       i_ir,
    input  logic             i_run,
    output logic             o_nop,
    output logic             o_halt,
    output logic             o_in1,
    output logic             o_out1,
    output logic             o_jmp,
    output logic             o_jz,
    output logic             o_jc,
    output logic             o_rsl,
    output logic             o_add,
    output logic             o_sub,
    output logic             o_and1,
    output logic             o_not1,
    output logic             o_mova,
    output logic             o_movb,
    output logic             o_movc,
    output logic             o_rsr,
    output logic             o_sm,
    output logic             o_run_en,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_instr_cnt
);

    state_t           r_state;
    logic             r_sm;
    logic             r_run_en;
    logic             r_halted;
    logic [CNT_W-1:0] r_instr_cnt;
    logic [OP_W-1:0]  w_op;
    logic             w_exec;
    logic             w_ir_unused;
    dec_t             w_dec;

    assign w_op        = i_ir[7:4];
    assign w_ir_unused = ^i_ir[3:0];
    assign w_exec      = (r_state == S_EXEC);

`ifdef SINGLE_STEP_EN
    logic r_step_meta;
    logic r_step_sync;
    logic r_step_prev;
    logic w_step_rise;

    assign w_step_rise = r_step_sync & ~r_step_prev;

    // Two-flop synchroniser plus edge-detect history for the asynchronous step request.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_step_meta <= 1'b0;
            r_step_sync <= 1'b0;
            r_step_prev <= 1'b0;
        end else begin
            r_step_meta <= i_step;
            r_step_sync <= r_step_meta;
            r_step_prev <= r_step_sync;
        end
    end
`endif

    // Sequencer; status outputs are registered alongside the state they describe.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_sm        <= 1'b0;
            r_run_en    <= 1'b0;
            r_halted    <= 1'b0;
            r_instr_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_run) begin
                        r_state  <= S_FETCH;
                        r_run_en <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_state  <= S_EXEC;
                    r_sm     <= 1'b1;
                    r_run_en <= 1'b1;
                end
                S_EXEC: begin
                    r_instr_cnt <= r_instr_cnt + CNT_W'(1);
                    if (w_op == OP_HALT) begin
                        r_state  <= S_HALTED;
                        r_sm     <= 1'b1;
                        r_run_en <= 1'b0;
                        r_halted <= 1'b1;
`ifdef SINGLE_STEP_EN
                    end else if (i_step_mode) begin
                        r_state  <= S_WAIT;
                        r_sm     <= 1'b0;
                        r_run_en <= 1'b0;
`endif
                    end else begin
                        r_state  <= S_FETCH;
                        r_sm     <= 1'b0;
                        r_run_en <= 1'b1;
                    end
                end
                S_HALTED: begin
                    r_state <= S_HALTED;
                end
`ifdef SINGLE_STEP_EN
                // Leave on a step edge, or immediately once single-step is switched off.
                S_WAIT: begin
                    if (w_step_rise || !i_step_mode) begin
                        r_state  <= S_FETCH;
                        r_run_en <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_state  <= S_IDLE;
                    r_sm     <= 1'b0;
                    r_run_en <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    instr_dec u_instr_dec (
        .i_op     (w_op),
        .i_exec   (w_exec),
        .i_halted (r_halted),
        .o_dec    (w_dec)
    );

    assign o_nop       = w_dec.nop;
    assign o_halt      = w_dec.halt;
    assign o_in1       = w_dec.in1;
    assign o_out1      = w_dec.out1;
    assign o_jmp       = w_dec.jmp;
    assign o_jz        = w_dec.jz;
    assign o_jc        = w_dec.jc;
    assign o_rsl       = w_dec.rsl;
    assign o_add       = w_dec.add;
    assign o_sub       = w_dec.sub;
    assign o_and1      = w_dec.and1;
    assign o_not1      = w_dec.not1;
    assign o_mova      = w_dec.mova;
    assign o_movb      = w_dec.movb;
    assign o_movc      = w_dec.movc;
    assign o_rsr       = w_dec.rsr;
    assign o_sm        = r_sm;
    assign o_run_en    = r_run_en;
    assign o_halted    = r_halted;
    assign o_instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_instr_seq.sv
// Directed self-checking bench for instr_seq (4-bit counter build to exercise wrap).
// Single-step vectors run only when SINGLE_STEP_EN is defined.
`timescale 1ns/1ps
module tb_instr_seq;

    localparam int unsigned TB_CNT_W = 4;

    logic                i_clk = 1'b0;
    logic                i_rst_n;
    logic [7:0]          i_ir;
    logic                i_run;
`ifdef SINGLE_STEP_EN
    logic                i_step_mode;
    logic                i_step;
`endif
    logic o_nop, o_halt, o_in1, o_out1, o_jmp, o_jz, o_jc, o_rsl;
    logic o_add, o_sub, o_and1, o_not1, o_mova, o_movb, o_movc, o_rsr;
    logic                o_sm;
    logic                o_run_en;
    logic                o_halted;
    logic [TB_CNT_W-1:0] o_instr_cnt;
    logic [15:0]         dec;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] ops [15] = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
                             4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

    always #5 i_clk = ~i_clk;

    assign dec = {o_rsr, o_movc, o_movb, o_mova, o_not1, o_and1, o_sub, o_add,
                  o_rsl, o_jc, o_jz, o_jmp, o_out1, o_in1, o_halt, o_nop};

    instr_seq #(.CNT_W(TB_CNT_W)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
`ifdef SINGLE_STEP_EN
        .i_step_mode (i_step_mode),
        .i_step      (i_step),
`endif
        .i_ir        (i_ir),
        .i_run       (i_run),
        .o_nop       (o_nop),
        .o_halt      (o_halt),
        .o_in1       (o_in1),
        .o_out1      (o_out1),
        .o_jmp       (o_jmp),
        .o_jz        (o_jz),
        .o_jc        (o_jc),
        .o_rsl       (o_rsl),
        .o_add       (o_add),
        .o_sub       (o_sub),
        .o_and1      (o_and1),
        .o_not1      (o_not1),
        .o_mova      (o_mova),
        .o_movb      (o_movb),
        .o_movc      (o_movc),
        .o_rsr       (o_rsr),
        .o_sm        (o_sm),
        .o_run_en    (o_run_en),
        .o_halted    (o_halted),
        .o_instr_cnt (o_instr_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample and drive 1ns after the rising edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic chk_status(input string tag, input logic sm, input logic run_en,
                              input logic halted, input logic [15:0] d,
                              input logic [TB_CNT_W-1:0] cnt);
        chk({tag, "_sm"},     32'(o_sm),        32'(sm));
        chk({tag, "_run_en"}, 32'(o_run_en),    32'(run_en));
        chk({tag, "_halted"}, 32'(o_halted),    32'(halted));
        chk({tag, "_dec"},    32'(dec),         32'(d));
        chk({tag, "_cnt"},    32'(o_instr_cnt), 32'(cnt));
    endtask

    initial begin
        logic [15:0] oh;
        logic [TB_CNT_W-1:0] exp_cnt;
        i_rst_n = 1'b0;
        i_run   = 1'b0;
        i_ir    = 8'h00;
`ifdef SINGLE_STEP_EN
        i_step_mode = 1'b0;
        i_step      = 1'b0;
`endif
        tick(2);
        chk_status("reset", 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0);
        i_rst_n = 1'b1;
        tick(10);
        chk_status("idle10", 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0);

        // add: FETCH then EXEC, counter bumps at end of EXEC
        i_run = 1'b1;
        tick();
        i_run = 1'b0;
        i_ir  = 8'h84;
        chk_status("add_fetch", 1'b0, 1'b1, 1'b0, 16'h0000, 4'd0);
        tick();
        chk_status("add_exec", 1'b1, 1'b1, 1'b0, 16'h0100, 4'd0);
        chk("add_line", 32'(o_add), 32'd1);
        tick();
        chk_status("add_after", 1'b0, 1'b1, 1'b0, 16'h0000, 4'd1);

        // jmp held on ir across FETCH must stay gated off until EXEC
        i_ir = 8'h40;
        #1;
        chk("jmp_in_fetch", 32'(o_jmp), 32'd0);
        tick();
        chk_status("jmp_exec", 1'b1, 1'b1, 1'b0, 16'h0010, 4'd1);
        tick();
        chk("jmp_after", 32'(o_jmp), 32'd0);
        chk("jmp_cnt", 32'(o_instr_cnt), 32'd2);

        // counter wrap: 17 non-halt instructions from a fresh reset
        i_rst_n = 1'b0;
        tick();
        chk_status("wrap_rst", 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0);
        i_rst_n = 1'b1;
        i_run   = 1'b1;
        tick();
        i_run   = 1'b0;
        exp_cnt = '0;
        for (int i = 0; i < 17; i++) begin
            i_ir = {ops[i % 15], 4'h5};
            oh   = 16'h0001 << ops[i % 15];
            tick();
            chk("wrap_exec_dec", 32'(dec), 32'(oh));
            tick();
            exp_cnt = exp_cnt + 4'd1;
            chk("wrap_cnt", 32'(o_instr_cnt), 32'(exp_cnt));
        end
        chk("wrap_final", 32'(o_instr_cnt), 32'd1);

        // halt: absorbing, run and ir ignored
        i_ir = 8'h10;
        tick();
        chk_status("halt_exec", 1'b1, 1'b1, 1'b0, 16'h0002, 4'd1);
        tick();
        chk_status("halted", 1'b1, 1'b0, 1'b1, 16'h0002, 4'd2);
        i_ir = 8'h84;
        for (int i = 0; i < 4; i++) begin
            i_run = ~i_run;
            tick();
        end
        chk_status("halted_hold", 1'b1, 1'b0, 1'b1, 16'h0002, 4'd2);
        i_run   = 1'b0;
        i_rst_n = 1'b0;
        tick();
        chk_status("halt_rst", 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0);
        i_rst_n = 1'b1;

        // reset in the middle of EXEC: no increment, back to IDLE
        i_run = 1'b1;
        tick();
        i_run = 1'b0;
        i_ir  = 8'h90;
        tick();
        chk("mid_exec_sub", 32'(dec), 32'h0200);
        i_rst_n = 1'b0;
        tick();
        chk_status("mid_exec_rst", 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0);
        i_rst_n = 1'b1;
        tick(3);
        chk_status("mid_exec_idle", 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0);

`ifdef SINGLE_STEP_EN
        begin
            bit seen;
            i_step_mode = 1'b1;
            i_ir        = 8'h00;
            i_run       = 1'b1;
            tick();
            i_run = 1'b0;
            tick();
            chk("ss_exec_nop", 32'(dec), 32'h0001);
            tick();
            chk_status("ss_wait0", 1'b0, 1'b0, 1'b0, 16'h0000, 4'd1);
            tick(5);
            chk_status("ss_wait0_hold", 1'b0, 1'b0, 1'b0, 16'h0000, 4'd1);
            for (int p = 0; p < 3; p++) begin
                i_step = 1'b1;
                tick(2);
                i_step = 1'b0;
                seen = 1'b0;
                for (int w = 0; w < 8 && !seen; w++) begin
                    if (o_run_en && !o_sm) seen = 1'b1;
                    else tick();
                end
                chk("ss_fetch_seen", 32'(seen), 32'd1);
                tick();
                chk("ss_exec_sm", 32'(o_sm), 32'd1);
                tick();
                chk_status("ss_wait", 1'b0, 1'b0, 1'b0, 16'h0000, 4'(p + 2));
                tick(4);
                chk("ss_wait_hold", 32'(o_run_en), 32'd0);
            end
            i_step_mode = 1'b0;
            tick();
            chk_status("ss_exit_fetch", 1'b0, 1'b1, 1'b0, 16'h0000, 4'd4);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_seq.md
INSTR_SEQ -- requirements
Module: instr_seq

Interface
REQ-001 Parameter: CNT_W, 16, width of retired-instruction counter.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 ir  in  8  current instruction register; opcode in ir[7:4].
REQ-005 run  in  1  level; starts execution when sampled high in IDLE.
REQ-006 step_mode  in  1  single-step select (SINGLE_STEP_EN only).
REQ-007 step  in  1  asynchronous step request (SINGLE_STEP_EN only).
REQ-008 nop, halt, in1, out1, jmp, jz, jc, rsl, add, sub, and1, not1, mova, movb, movc, rsr  out  1 each  one-hot decoded instruction lines.
REQ-009 sm  out  1  beat: 0 = fetch, 1 = execute.
REQ-010 run_en  out  1  datapath write enable; high only in FETCH and EXEC.
REQ-011 halted  out  1  high in HALTED.
REQ-012 instr_cnt  out  CNT_W  retired-instruction count.

Function
REQ-013 States: IDLE, FETCH, EXEC, HALTED, WAIT (WAIT only with SINGLE_STEP_EN); state is registered.
REQ-014 Opcode map ir[7:4]: 0 nop, 1 halt, 2 in1, 3 out1, 4 jmp, 5 jz, 6 jc, 7 rsl, 8 add, 9 sub, A and1, B not1, C mova, D movb, E movc, F rsr.
REQ-015 Decode is combinational from ir, gated: exactly one line high in EXEC; all lines 0 in IDLE, FETCH, WAIT (prevents stale jmp/pc_ld during fetch).
REQ-016 In HALTED the halt line is held high and all other decode lines 0.
REQ-017 sm = 1 in EXEC and HALTED; 0 otherwise.
REQ-018 IDLE -> FETCH when run = 1; otherwise remain IDLE; run ignored outside IDLE.
REQ-019 FETCH -> EXEC unconditionally after one cycle (ir loaded at end of FETCH by downstream ir_ld).
REQ-020 EXEC with opcode 1 -> HALTED; other opcodes -> FETCH (or WAIT, REQ-027).
REQ-021 HALTED is absorbing; exit only by reset.
REQ-022 instr_cnt increments by 1 at end of every EXEC cycle, including halt; wraps all-ones -> 0; never increments in other states.
REQ-023 Latency: first decoded instruction visible 2 cycles after run sampled high in IDLE.

Reset
REQ-024 rst_n low at clk edge forces IDLE, instr_cnt = 0, step synchroniser/edge flops = 0, regardless of current state (including mid-EXEC or HALTED).
REQ-025 Output values during/after reset: sm = 0, run_en = 0, halted = 0, all decode lines 0.

Configuration
REQ-026 Macro SINGLE_STEP_EN: when defined, step_mode, step ports, WAIT state and step logic exist; when undefined, these are absent and EXEC always -> FETCH (or HALTED).
REQ-027 With macro: EXEC (non-halt) -> WAIT when step_mode = 1; WAIT -> FETCH on one detected step rising edge; run_en = 0, sm = 0 in WAIT.
REQ-028 step passes a 2-flop synchroniser then a rising-edge detector; one edge = exactly one instruction; edges outside WAIT discarded; step_mode cleared in WAIT -> FETCH next cycle.

Structure
REQ-029 Shared package holds opcode constants (REQ-014) and state encoding; control-signal generator imports the same opcode constants.
REQ-030 One sub-module natural: instr_dec (gated combinational opcode-to-one-hot decoder); sequencer, counter, step logic in instr_seq.

Verification
REQ-031 Reset, run = 0 for 10 cycles -> IDLE, run_en = 0, all decodes 0, instr_cnt = 0.
REQ-032 run = 1, ir = 0x84 loaded -> FETCH then EXEC with add = 1, sm = 1 only in EXEC, instr_cnt = 1 after EXEC.
REQ-033 ir = 0x40 across FETCH -> jmp = 0 in FETCH, jmp = 1 only in EXEC cycle.
REQ-034 ir = 0x10 in EXEC -> HALTED next cycle, halted = 1, halt = 1, sm = 1, run_en = 0; run toggling has no effect; rst_n low -> IDLE.
REQ-035 CNT_W = 4, 17 non-halt instructions -> instr_cnt wraps 15 -> 0, reads 1.
REQ-036 SINGLE_STEP_EN, step_mode = 1, 3 step pulses (incl. one during EXEC) -> exactly 3 more instructions retire; WAIT between each with run_en = 0.
